// File: rtl/rv32i_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the RV32I decode stage.
// slave is the decode stage's own view, master is the view of whatever drives it.
interface rv32i_decode_stage_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic            ready_o;
   logic [31:0]     instr_i;
   logic [XLEN-1:0] pc_i;
   logic            valid_o;
   logic            ready_i;
   logic [4:0]      op_o;
   logic [2:0]      funct3_o;
   logic [4:0]      rs1_o;
   logic [4:0]      rs2_o;
   logic [4:0]      rd_o;
   logic [XLEN-1:0] imm_o;
   logic [XLEN-1:0] pc_o;
   logic            illegal_o;

   modport slave (
      input  valid_i, instr_i, pc_i, ready_i,
      output ready_o, valid_o, op_o, funct3_o, rs1_o, rs2_o, rd_o, imm_o, pc_o, illegal_o
   );

   modport master (
      output valid_i, instr_i, pc_i, ready_i,
      input  ready_o, valid_o, op_o, funct3_o, rs1_o, rs2_o, rd_o, imm_o, pc_o, illegal_o
   );
endinterface

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decoder, 1 cycle latency, full throughput via an OUT + SKID pair.
// Backpressure: one extra word lands in SKID while OUT stalls; ready_o is simply !SKID.valid.
module rv32i_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   rv32i_decode_stage_if.slave  bus
);
   typedef enum logic [4:0] {
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
      OP_SRAI, OP_LUI, OP_AUIPC, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SLL,
      OP_SRL, OP_SRA, OP_AND, OP_OR, OP_XOR, OP_JAL, OP_JALR, OP_BEQ,
      OP_BNE, OP_BLT, OP_BLTU, OP_BGE, OP_BGEU, OP_LOAD, OP_STORE, OP_ILLEGAL
   } op_e;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

   typedef struct packed {
      logic [4:0]      op;
      logic [2:0]      funct3;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } meta_t;

   logic [31:0] ins;
   logic [2:0]  f3;
   logic [6:0]  f7;
   op_e         op;
   fmt_e        fmt;
   meta_t       dec;
   meta_t       out_dat, skid_dat;
   logic        out_vld, skid_vld;
   logic        accept;

   assign ins = bus.instr_i;
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];

   always_comb begin
      op  = OP_ILLEGAL;
      fmt = FMT_X;
      if (ins[1:0] == 2'b11) begin
         case (ins[6:2])
            5'b01101: begin op = OP_LUI;   fmt = FMT_U; end
            5'b00101: begin op = OP_AUIPC; fmt = FMT_U; end
            5'b11011: begin op = OP_JAL;   fmt = FMT_J; end
            5'b11001: if (f3 == 3'b000) begin op = OP_JALR; fmt = FMT_I; end
            5'b11000: begin
               fmt = FMT_B;
               case (f3)
                  3'b000:  op = OP_BEQ;
                  3'b001:  op = OP_BNE;
                  3'b100:  op = OP_BLT;
                  3'b101:  op = OP_BGE;
                  3'b110:  op = OP_BLTU;
                  3'b111:  op = OP_BGEU;
                  default: fmt = FMT_X;
               endcase
            end
            5'b00000: if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
               op = OP_LOAD; fmt = FMT_I;
            end
            5'b01000: if (f3 <= 3'b010) begin op = OP_STORE; fmt = FMT_S; end
            5'b00100: begin
               fmt = FMT_I;
               case (f3)
                  3'b000: op = OP_ADDI;
                  3'b010: op = OP_SLTI;
                  3'b011: op = OP_SLTIU;
                  3'b100: op = OP_XORI;
                  3'b110: op = OP_ORI;
                  3'b111: op = OP_ANDI;
                  3'b001: begin
                     fmt = (f7 == 7'b0000000) ? FMT_SH : FMT_X;
                     if (f7 == 7'b0000000) op = OP_SLLI;
                  end
                  default: begin
                     fmt = FMT_SH;
                     if (f7 == 7'b0000000)      op = OP_SRLI;
                     else if (f7 == 7'b0100000) op = OP_SRAI;
                     else                       fmt = FMT_X;
                  end
               endcase
            end
            5'b01100: begin
               fmt = FMT_R;
               if (f7 == 7'b0000000) begin
                  case (f3)
                     3'b000:  op = OP_ADD;
                     3'b001:  op = OP_SLL;
                     3'b010:  op = OP_SLT;
                     3'b011:  op = OP_SLTU;
                     3'b100:  op = OP_XOR;
                     3'b101:  op = OP_SRL;
                     3'b110:  op = OP_OR;
                     default: op = OP_AND;
                  endcase
               end else if (f7 == 7'b0100000 && f3 == 3'b000) op = OP_SUB;
               else if (f7 == 7'b0100000 && f3 == 3'b101)     op = OP_SRA;
               else                                           fmt = FMT_X;
            end
            default: ;
         endcase
      end
   end

   // Register indexes and immediate follow the format; an illegal word keeps them all zero.
   always_comb begin
      dec         = '0;
      dec.op      = op;
      dec.funct3  = f3;
      dec.pc      = bus.pc_i;
      dec.illegal = (op == OP_ILLEGAL);
      case (fmt)
         FMT_R:  begin dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20]; dec.rd = ins[11:7]; end
         FMT_I:  begin
            dec.rs1 = ins[19:15]; dec.rd = ins[11:7];
            dec.imm = {{20{ins[31]}}, ins[31:20]};
         end
         FMT_SH: begin
            dec.rs1 = ins[19:15]; dec.rd = ins[11:7];
            dec.imm = {27'b0, ins[24:20]};
         end
         FMT_S:  begin
            dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20];
            dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         end
         FMT_B:  begin
            dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20];
            dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         end
         FMT_U:  begin dec.rd = ins[11:7]; dec.imm = {ins[31:12], 12'b0}; end
         FMT_J:  begin
            dec.rd  = ins[11:7];
            dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   assign accept = bus.valid_i & ~skid_vld;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         out_dat  <= '0;
         skid_dat <= '0;
      end else if (flush_i) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (!out_vld || bus.ready_i) begin
         // SKID always holds the younger word, so it refills OUT before any new input.
         if (skid_vld) begin
            out_dat  <= skid_dat;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else begin
            out_vld <= accept;
            if (accept) out_dat <= dec;
         end
      end else if (accept) begin
         skid_dat <= dec;
         skid_vld <= 1'b1;
      end
   end

   assign bus.ready_o   = ~skid_vld;
   assign bus.valid_o   = out_vld;
   assign bus.op_o      = out_dat.op;
   assign bus.funct3_o  = out_dat.funct3;
   assign bus.rs1_o     = out_dat.rs1;
   assign bus.rs2_o     = out_dat.rs2;
   assign bus.rd_o      = out_dat.rd;
   assign bus.imm_o     = out_dat.imm;
   assign bus.pc_o      = out_dat.pc;
   assign bus.illegal_o = out_dat.illegal;
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: accepted words are decoded by a mask/match reference
// model into a queue and compared against each bundle the stage hands downstream.
module tb_rv32i_decode_stage;
   typedef struct packed {
      logic [4:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   rv32i_decode_stage_if #(.XLEN(32)) bus ();

   rv32i_decode_stage #(.XLEN(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      logic [4:0] op;
      op = 5'd31;
      if ((w & 32'h0000007F) == 32'h00000037) op = 5'd9;
      if ((w & 32'h0000007F) == 32'h00000017) op = 5'd10;
      if ((w & 32'h0000007F) == 32'h0000006F) op = 5'd21;
      if ((w & 32'h0000707F) == 32'h00000067) op = 5'd22;
      if ((w & 32'h0000707F) == 32'h00000063) op = 5'd23;
      if ((w & 32'h0000707F) == 32'h00001063) op = 5'd24;
      if ((w & 32'h0000707F) == 32'h00004063) op = 5'd25;
      if ((w & 32'h0000707F) == 32'h00005063) op = 5'd27;
      if ((w & 32'h0000707F) == 32'h00006063) op = 5'd26;
      if ((w & 32'h0000707F) == 32'h00007063) op = 5'd28;
      if ((w & 32'h0000707F) == 32'h00000003) op = 5'd29;
      if ((w & 32'h0000707F) == 32'h00001003) op = 5'd29;
      if ((w & 32'h0000707F) == 32'h00002003) op = 5'd29;
      if ((w & 32'h0000707F) == 32'h00004003) op = 5'd29;
      if ((w & 32'h0000707F) == 32'h00005003) op = 5'd29;
      if ((w & 32'h0000707F) == 32'h00000023) op = 5'd30;
      if ((w & 32'h0000707F) == 32'h00001023) op = 5'd30;
      if ((w & 32'h0000707F) == 32'h00002023) op = 5'd30;
      if ((w & 32'h0000707F) == 32'h00000013) op = 5'd0;
      if ((w & 32'h0000707F) == 32'h00002013) op = 5'd1;
      if ((w & 32'h0000707F) == 32'h00003013) op = 5'd2;
      if ((w & 32'h0000707F) == 32'h00004013) op = 5'd5;
      if ((w & 32'h0000707F) == 32'h00006013) op = 5'd4;
      if ((w & 32'h0000707F) == 32'h00007013) op = 5'd3;
      if ((w & 32'hFE00707F) == 32'h00001013) op = 5'd6;
      if ((w & 32'hFE00707F) == 32'h00005013) op = 5'd7;
      if ((w & 32'hFE00707F) == 32'h40005013) op = 5'd8;
      if ((w & 32'hFE00707F) == 32'h00000033) op = 5'd11;
      if ((w & 32'hFE00707F) == 32'h40000033) op = 5'd12;
      if ((w & 32'hFE00707F) == 32'h00001033) op = 5'd15;
      if ((w & 32'hFE00707F) == 32'h00002033) op = 5'd13;
      if ((w & 32'hFE00707F) == 32'h00003033) op = 5'd14;
      if ((w & 32'hFE00707F) == 32'h00004033) op = 5'd20;
      if ((w & 32'hFE00707F) == 32'h00005033) op = 5'd16;
      if ((w & 32'hFE00707F) == 32'h40005033) op = 5'd17;
      if ((w & 32'hFE00707F) == 32'h00006033) op = 5'd19;
      if ((w & 32'hFE00707F) == 32'h00007033) op = 5'd18;
      e     = '0;
      e.op  = op;
      e.f3  = w[14:12];
      e.pc  = pc;
      e.ill = (op == 5'd31);
      if (op inside {[5'd11:5'd20]}) begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; end
      if (op inside {[5'd0:5'd8], 5'd22, 5'd29}) begin e.rs1 = w[19:15]; e.rd = w[11:7]; end
      if (op inside {[5'd0:5'd5], 5'd22, 5'd29}) e.imm = {{20{w[31]}}, w[31:20]};
      if (op inside {[5'd6:5'd8]}) e.imm = {27'b0, w[24:20]};
      if (op inside {5'd9, 5'd10}) begin e.rd = w[11:7]; e.imm = {w[31:12], 12'b0}; end
      if (op == 5'd21) begin
         e.rd  = w[11:7];
         e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      if (op inside {[5'd23:5'd28], 5'd30}) begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
      if (op inside {[5'd23:5'd28]}) e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      if (op == 5'd30) e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      return e;
   endfunction

   function automatic exp_t observe();
      return {bus.op_o, bus.funct3_o, bus.rs1_o, bus.rs2_o, bus.rd_o, bus.imm_o, bus.pc_o, bus.illegal_o};
   endfunction

   // One clock: inputs are already set; handshakes are sampled mid-cycle, scoreboard updated after the edge.
   task automatic tick(output bit acc);
      bit   drn, stall;
      exp_t got, exp;
      acc   = bus.valid_i && bus.ready_o && !flush;
      drn   = bus.valid_o && bus.ready_i && !flush;
      stall = bus.valid_o && !bus.ready_i && !flush;
      got   = observe();
      @(posedge clk);
      @(negedge clk);
      if (flush) sb.delete();
      else begin
         if (drn) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL scoreboard underflow: got bundle %h, required no output", got);
            end else begin
               exp = sb.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL bundle: got %h required %h", got, exp);
               end
            end
         end
         if (stall) begin
            checks++;
            if (observe() !== got || bus.valid_o !== 1'b1) begin
               errors++;
               $display("FAIL stall hold: got %h valid=%b required %h valid=1", observe(), bus.valid_o, got);
            end
         end
         if (acc) sb.push_back(model(bus.instr_i, bus.pc_i));
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset handshake: valid_o=%b ready_o=%b required 0/1", bus.valid_o, bus.ready_o);
      end
      checks++;
      if (observe() !== '0) begin
         errors++;
         $display("FAIL reset outputs: got %h required 0", observe());
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_addi();
      bit acc;
      bus.ready_i = 1'b1;
      bus.valid_i = 1'b1; bus.instr_i = 32'hFFF10093; bus.pc_i = 32'h0000_0040;
      tick(acc);
      bus.valid_i = 1'b0;
      checks++;
      if (!acc || bus.valid_o !== 1'b1 || bus.op_o !== 5'd0 || bus.rs1_o !== 5'd2 || bus.rd_o !== 5'd1 ||
          bus.rs2_o !== 5'd0 || bus.imm_o !== 32'hFFFFFFFF || bus.illegal_o !== 1'b0) begin
         errors++;
         $display("FAIL addi: acc=%b v=%b op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ill=%b required 1 1 0 2 0 1 ffffffff 0",
                  acc, bus.valid_o, bus.op_o, bus.rs1_o, bus.rs2_o, bus.rd_o, bus.imm_o, bus.illegal_o);
      end
      tick(acc);
   endtask

   task automatic test_back_to_back();
      bit acc;
      bus.ready_i = 1'b1;
      bus.valid_i = 1'b1; bus.instr_i = 32'h402081B3; bus.pc_i = 32'h0000_0080;
      tick(acc);
      checks++;
      if (bus.op_o !== 5'd12 || bus.rs1_o !== 5'd1 || bus.rs2_o !== 5'd2 || bus.rd_o !== 5'd3 || bus.imm_o !== 32'h0) begin
         errors++;
         $display("FAIL sub: op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h required 12 1 2 3 0",
                  bus.op_o, bus.rs1_o, bus.rs2_o, bus.rd_o, bus.imm_o);
      end
      bus.instr_i = 32'h123452B7; bus.pc_i = 32'h0000_0084;
      tick(acc);
      bus.valid_i = 1'b0;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.op_o !== 5'd9 || bus.rd_o !== 5'd5 || bus.imm_o !== 32'h12345000) begin
         errors++;
         $display("FAIL lui: v=%b op=%0d rd=%0d imm=%h required 1 9 5 12345000",
                  bus.valid_o, bus.op_o, bus.rd_o, bus.imm_o);
      end
      tick(acc);
   endtask

   task automatic test_branch();
      bit acc;
      bus.ready_i = 1'b1;
      bus.valid_i = 1'b1; bus.instr_i = 32'hFE000EE3; bus.pc_i = 32'h0000_0100;
      tick(acc);
      bus.valid_i = 1'b0;
      checks++;
      if (bus.op_o !== 5'd23 || bus.imm_o !== 32'hFFFFFFFC || bus.rd_o !== 5'd0 || bus.pc_o !== 32'h100) begin
         errors++;
         $display("FAIL beq: op=%0d imm=%h rd=%0d pc=%h required 23 fffffffc 0 00000100",
                  bus.op_o, bus.imm_o, bus.rd_o, bus.pc_o);
      end
      tick(acc);
   endtask

   task automatic test_illegal();
      bit acc;
      logic [31:0] words [3];
      words[0] = 32'h00000000; words[1] = 32'h4210D093; words[2] = 32'h00000073;
      bus.ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.valid_i = 1'b1; bus.instr_i = words[i]; bus.pc_i = 32'h200 + 32'(i * 4);
         tick(acc);
         checks++;
         if (bus.op_o !== 5'd31 || bus.illegal_o !== 1'b1 || bus.imm_o !== 32'h0 || bus.pc_o !== 32'h200 + 32'(i * 4)) begin
            errors++;
            $display("FAIL illegal[%0d]: op=%0d ill=%b imm=%h pc=%h required 31 1 0 %h",
                     i, bus.op_o, bus.illegal_o, bus.imm_o, bus.pc_o, 32'h200 + 32'(i * 4));
         end
      end
      bus.valid_i = 1'b0;
      tick(acc);
   endtask

   task automatic test_backpressure();
      bit acc;
      int n_acc = 0;
      int idx = 0;
      logic [31:0] words [3];
      words[0] = 32'h05547393; words[1] = 32'h402081B3; words[2] = 32'h123452B7;
      bus.ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         bus.valid_i = 1'b1; bus.instr_i = words[idx]; bus.pc_i = 32'h300 + 32'(idx * 4);
         tick(acc);
         if (acc) begin n_acc++; if (idx < 2) idx++; end
      end
      checks++;
      if (n_acc != 2 || bus.ready_o !== 1'b0 || bus.op_o !== 5'd3) begin
         errors++;
         $display("FAIL backpressure fill: accepted=%0d ready_o=%b op=%0d required 2 0 3", n_acc, bus.ready_o, bus.op_o);
      end
      bus.ready_i = 1'b1;
      tick(acc);
      checks++;
      if (acc || bus.op_o !== 5'd12) begin
         errors++;
         $display("FAIL backpressure drain1: accepted=%b op=%0d required 0 12", acc, bus.op_o);
      end
      tick(acc);
      checks++;
      if (!acc || bus.op_o !== 5'd9) begin
         errors++;
         $display("FAIL backpressure drain2: accepted=%b op=%0d required 1 9", acc, bus.op_o);
      end
      bus.valid_i = 1'b0;
      tick(acc);
   endtask

   task automatic test_flush();
      bit acc;
      int n_acc = 0;
      bus.ready_i = 1'b0;
      for (int c = 0; c < 4 && n_acc < 2; c++) begin
         bus.valid_i = 1'b1; bus.instr_i = 32'h00A00513 + 32'(n_acc << 20); bus.pc_i = 32'h400 + 32'(n_acc * 4);
         tick(acc);
         if (acc) n_acc++;
      end
      checks++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL flush prefill: valid_o=%b ready_o=%b required 1 0", bus.valid_o, bus.ready_o);
      end
      bus.valid_i = 1'b1; bus.instr_i = 32'h123452B7; bus.ready_i = 1'b1; flush = 1'b1;
      tick(acc);
      flush = 1'b0; bus.valid_i = 1'b0;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL flush: valid_o=%b ready_o=%b required 0 1", bus.valid_o, bus.ready_o);
      end
      for (int c = 0; c < 3; c++) begin
         tick(acc);
         checks++;
         if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush leak[%0d]: valid_o=%b op=%0d required valid_o 0", c, bus.valid_o, bus.op_o);
         end
      end
   endtask

   task automatic test_reset_midstream();
      bit acc;
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1; bus.instr_i = 32'hFFF10093; bus.pc_i = 32'h500;
      tick(acc);
      bus.instr_i = 32'h402081B3;
      tick(acc);
      bus.valid_i = 1'b0;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL pre-reset fill: valid_o=%b ready_o=%b required 1 0", bus.valid_o, bus.ready_o);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || observe() !== '0) begin
         errors++;
         $display("FAIL async reset: valid_o=%b ready_o=%b bundle=%h required 0 1 0", bus.valid_o, bus.ready_o, observe());
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      bit acc;
      logic [6:0] opcs [11];
      logic [31:0] w;
      opcs[0] = 7'h37; opcs[1] = 7'h17; opcs[2] = 7'h6F; opcs[3] = 7'h67; opcs[4] = 7'h63; opcs[5] = 7'h03;
      opcs[6] = 7'h23; opcs[7] = 7'h13; opcs[8] = 7'h33; opcs[9] = 7'h0F; opcs[10] = 7'h73;
      for (int c = 0; c < 400; c++) begin
         if (!(bus.valid_i && !bus.ready_o) || $urandom_range(0, 3) == 0) begin
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
            case ($urandom_range(0, 3))
               0: w[31:25] = 7'h00;
               1: w[31:25] = 7'h20;
               default: ;
            endcase
            bus.instr_i = w;
            bus.pc_i    = $urandom & 32'hFFFF_FFFC;
            bus.valid_i = ($urandom_range(0, 3) != 0);
         end
         bus.ready_i = ($urandom_range(0, 2) != 0);
         tick(acc);
      end
      bus.valid_i = 1'b0; bus.ready_i = 1'b1;
      for (int c = 0; c < 4; c++) tick(acc);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL random drain: %0d bundles never emerged, required 0", sb.size());
      end
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.instr_i = '0;
      bus.pc_i    = '0;
      test_reset();
      test_addi();
      test_back_to_back();
      test_branch();
      test_illegal();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rv32i_decode_stage.md
# rv32i_decode_stage

Registered RV32I instruction decoder between fetch and the execute units. Each accepted 32-bit instruction word and its PC become an operation code, register indexes, a fully expanded 32-bit immediate and an illegal flag. These fields are exactly the operand form consumed by the integer, jump, branch and load/store execute units. Valid/ready on both sides with a 2-entry skid buffer: full throughput and a registered `ready_o`.

## Interface
- `XLEN`, 32: datapath width; only 32 supported.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: synchronous kill of all buffered instructions.
- `valid_i` in 1: fetch presents `instr_i`/`pc_i`.
- `ready_o` out 1: stage can accept; transfer when `valid_i & ready_o`.
- `instr_i` in 32: instruction word.
- `pc_i` in XLEN: instruction address.
- `valid_o` out 1: decoded bundle valid.
- `ready_i` in 1: downstream accepts; transfer when `valid_o & ready_i`.
- `op_o` out 5: operation code. ADDI 0, SLTI 1, SLTIU 2, ANDI 3, ORI 4, XORI 5, SLLI 6, SRLI 7, SRAI 8, LUI 9, AUIPC 10, ADD 11, SUB 12, SLT 13, SLTU 14, SLL 15, SRL 16, SRA 17, AND 18, OR 19, XOR 20, JAL 21, JALR 22, BEQ 23, BNE 24, BLT 25, BLTU 26, BGE 27, BGEU 28, LOAD 29, STORE 30, ILLEGAL 31.
- `funct3_o` out 3: raw `instr[14:12]`; gives the access size and sign for LOAD/STORE.
- `rs1_o`, `rs2_o`, `rd_o` out 5 each: register indexes, forced to 0 when unused.
- `imm_o` out XLEN: expanded immediate.
- `pc_o` out XLEN: PC of the bundle.
- `illegal_o` out 1: instruction not decodable by this stage.

## Operation
- **Decode** is combinational on `instr_i` and is captured at acceptance.

**Immediates**
- I-type (ALU-imm, LOAD, JALR): `sext(instr[31:20])`.
- Shifts: `{27'b0, instr[24:20]}`.
- S-type: `sext({instr[31:25], instr[11:7]})`.
- B-type: `sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})`.
- U-type: `{instr[31:12], 12'b0}`.
- J-type: `sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})`.
- R-type and ILLEGAL: 0.

**Register usage**
- R-type: rs1, rs2, rd.
- ALU-imm, shift, LOAD, JALR: rs1, rd.
- LUI, AUIPC, JAL: rd only.
- BRANCH, STORE: rs1, rs2.
- Unused fields output 0.

**Illegal conditions** (each gives `op_o` = 31, `illegal_o` = 1, `imm_o` = 0, all register indexes 0)
- `instr[1:0] != 2'b11`.
- Opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}; MISC-MEM and SYSTEM are included in this.
- JALR with funct3 ≠ 000.
- BRANCH with funct3 010 or 011.
- LOAD with funct3 ∉ {000, 001, 010, 100, 101}.
- STORE with funct3 > 010.
- SLLI/SRLI with funct7 ≠ 0000000.
- SRAI with funct7 ≠ 0100000.
- OP with funct7 ∉ {0000000, 0100000}.
- OP with funct7 0100000 and funct3 ∉ {000, 101}.
- Illegal instructions still flow through the pipeline in order; they are not dropped.

**Buffering**
- Output register (OUT) plus skid register (SKID).
- `ready_o` = !SKID.valid, registered.

**Per-cycle behaviour**
- OUT empty or draining (`ready_i`): OUT loads SKID if SKID is valid, else the new input.
- OUT full and stalled while an input is accepted: input goes into SKID.
- Order is always preserved: OUT holds the older instruction, SKID the younger.

## Timing
- **Reset values:** `valid_o` = 0, `ready_o` = 1, every other output 0, SKID empty.
- **Latency:** an instruction accepted at edge N is on the outputs with `valid_o` = 1 after edge N. Throughput is 1 per cycle while `ready_i` = 1.
- **Stall:** outputs hold stable while `valid_o & !ready_i`.
- **Backpressure:** with OUT stalled, one more instruction is accepted into SKID; `ready_o` falls the cycle after that acceptance.
  - After `ready_i` rises: OUT drains, SKID moves to OUT, and `ready_o` rises on the following edge.
- **Simultaneous drain and accept with SKID empty:** the new input goes directly to OUT; no bubble.
- **Flush:**
  - `flush_i` clears OUT and SKID at the next edge and overrides any same-cycle acceptance; that input is discarded.
  - After the flush, `valid_o` = 0 and `ready_o` = 1.
- **Reset mid-stream:** asynchronous, so all buffered instructions are lost immediately.

## Test plan
- **ADDI x1,x2,-1** (`0xFFF10093`), `ready_i` = 1 → next cycle: `op_o` = 0, `rs1_o` = 2, `rd_o` = 1, `rs2_o` = 0, `imm_o` = `0xFFFFFFFF`, `illegal_o` = 0.
- **SUB x3,x1,x2** (`0x402081B3`) followed by **LUI x5,0x12345** (`0x123452B7`) on back-to-back cycles → consecutive outputs:
  - SUB: `op_o` = 12, rs1 = 1, rs2 = 2, rd = 3, imm 0.
  - LUI: `op_o` = 9, rd = 5, `imm_o` = `0x12345000`.
- **BEQ x0,x0,-4** (`0xFE000EE3`) at `pc_i` = `0x100` → `op_o` = 23, `imm_o` = `0xFFFFFFFC`, `rd_o` = 0, `pc_o` = `0x100`.
- **Illegal words** `0x00000000`, SRAI with funct7 `0100001` (`0x4210D093`), and ECALL `0x00000073` → each gives `op_o` = 31, `illegal_o` = 1, `imm_o` = 0, and they appear in order.
- **Backpressure:** `ready_i` = 0 while 3 instructions are offered → exactly 2 accepted and `ready_o` = 0. Raise `ready_i` → the 2 drain in order on consecutive cycles, then the third is accepted.
- **Flush with both entries full and `valid_i` = 1:**
  - Next cycle: `valid_o` = 0, `ready_o` = 1, nothing from before the flush emerges.
  - Separately, `rst_i` pulsed mid-stream → outputs return to their reset values at once.
